// File: rtl/cpu_sequencer_if.sv
// ---------------------------------------------------------------------------
// cpu_sequencer_if
//   Memory / d_bus port between the fetch-execute sequencer and the
//   program/data memory plus the ALU's shared data bus.
//
//   addr      5  memory address
//   mem_rd    1  read request
//   mem_wr    1  write request (ALU drives d_bus)
//   bus_oe    1  ALU d_bus output enable
//   mem_rdata 8  read data returned by memory
//   mem_ready 1  access completes this cycle
//
//   master: the sequencer; slave: the memory side.
// ---------------------------------------------------------------------------
interface cpu_sequencer_if;
  logic [4:0] addr;
  logic       mem_rd;
  logic       mem_wr;
  logic       bus_oe;
  logic [7:0] mem_rdata;
  logic       mem_ready;

  modport master (
    output addr, mem_rd, mem_wr, bus_oe,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  addr, mem_rd, mem_wr, bus_oe,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/cpu_sequencer.sv
// ---------------------------------------------------------------------------
// cpu_sequencer
//   Fetch/execute controller for the 8-bit accumulator CPU. Owns the PC and
//   the instruction register, sequences the memory port and the ALU d_bus,
//   issues one-cycle ALU strobes and resolves JC/JZ from the ALU flags.
//
//   tclk     in   clock, rising edge
//   reset    in   asynchronous, active-high reset
//   run      in   keep executing (sampled at instruction completion)
//   bus      if   memory / d_bus port (master side)
//   c, z     in   ALU carry / zero flags
//   alu_en   out  one-cycle ALU execute strobe
//   ir       out  instruction register (ALU instruction input)
//   state    out  FSM state (ALU state input)
//   pc       out  program counter
//   busy     out  state != IDLE
//   bus_err  out  sticky memory wait-limit timeout
// ---------------------------------------------------------------------------
module cpu_sequencer #(
  parameter logic [4:0]  RESET_PC   = 5'd0,
  parameter int unsigned WAIT_LIMIT = 8
) (
  input  logic            tclk,
  input  logic            reset,
  input  logic            run,
  cpu_sequencer_if.master bus,
  input  logic            c,
  input  logic            z,
  output logic            alu_en,
  output logic [7:0]      ir,
  output logic [1:0]      state,
  output logic [4:0]      pc,
  output logic            busy,
  output logic            bus_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    EXEC  = 2'b10,
    WRITE = 2'b11
  } state_t;

  typedef enum logic [2:0] {
    OP_ADD   = 3'b000,
    OP_SUB   = 3'b001,
    OP_NAND  = 3'b010,
    OP_SHIFT = 3'b011,
    OP_LD    = 3'b100,
    OP_ST    = 3'b101,
    OP_JC    = 3'b110,
    OP_JZ    = 3'b111
  } opcode_t;

  // Last wait-count value before a still-pending access is declared dead.
  localparam logic [7:0] WAIT_LAST = 8'(WAIT_LIMIT - 1);

  state_t     state_q;
  logic [7:0] wait_cnt;
  logic       mem_req;     // a memory access is outstanding this cycle
  logic       exec_reads;  // current opcode reads its operand in EXEC
  opcode_t    opcode;
  logic [4:0] operand;
  state_t     next_instr;  // where to go once an instruction completes

  assign opcode     = opcode_t'(ir[7:5]);
  assign operand    = ir[4:0];
  assign exec_reads = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                      (opcode == OP_NAND) || (opcode == OP_LD);
  assign next_instr = run ? FETCH : IDLE;
  assign state      = state_q;
  assign busy       = (state_q != IDLE);

  // Bus strobes are combinational so the ALU strobe can follow mem_ready in
  // the same cycle the operand arrives.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    bus.addr   = '0;
    bus.mem_rd = 1'b0;
    bus.mem_wr = 1'b0;
    bus.bus_oe = 1'b0;
    alu_en     = 1'b0;
    mem_req    = 1'b0;
    case (state_q)
      FETCH: begin
        bus.addr   = pc;
        bus.mem_rd = 1'b1;
        mem_req    = 1'b1;
      end
      EXEC: begin
        bus.addr = operand;
        if (exec_reads) begin
          bus.mem_rd = 1'b1;
          mem_req    = 1'b1;
          alu_en     = bus.mem_ready;
        end else begin
          // SHIFT works on the accumulator, ST makes the ALU latch acc for
          // the following write; jumps never touch the ALU.
          alu_en = (opcode == OP_SHIFT) || (opcode == OP_ST);
        end
      end
      WRITE: begin
        bus.addr   = operand;
        bus.mem_wr = 1'b1;
        bus.bus_oe = 1'b1;
        mem_req    = 1'b1;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge tclk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      pc       <= RESET_PC;
      ir       <= '0;
      wait_cnt <= '0;
      bus_err  <= 1'b0;
    end else if (mem_req && !bus.mem_ready) begin
      // Stalled access: count, and give up once the limit is used up.
      // pc and ir are left untouched so the failing address stays visible.
      if (wait_cnt == WAIT_LAST) begin
        bus_err  <= 1'b1;
        state_q  <= IDLE;
        wait_cnt <= '0;
      end else begin
        wait_cnt <= wait_cnt + 8'd1;
      end
    end else begin
      // Either no access is pending or it completes now; every completing
      // access changes state, so the counter restarts for the next one.
      wait_cnt <= '0;
      case (state_q)
        IDLE: begin
          if (run && !bus_err) state_q <= FETCH;
        end
        FETCH: begin
          ir      <= bus.mem_rdata;
          pc      <= pc + 5'd1;
          state_q <= EXEC;
        end
        EXEC: begin
          case (opcode)
            OP_LD: state_q <= next_instr;
            OP_JC: begin
              if (c) pc <= operand;
              state_q <= next_instr;
            end
            OP_JZ: begin
              if (z) pc <= operand;
              state_q <= next_instr;
            end
            default: state_q <= WRITE;
          endcase
        end
        WRITE: state_q <= next_instr;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_cpu_sequencer
//   Directed bench for cpu_sequencer. A small program in a bench-side memory
//   exercises LD, ADD with a slow operand, taken/not-taken jumps, SHIFT, ST
//   with run dropped mid-write, PC wrap, the wait-limit timeout and an
//   asynchronous reset in the middle of an access. An instruction-level
//   model predicts every output on every cycle; literal checks pin the
//   hand-computed moments of the sequence.
// ---------------------------------------------------------------------------
module tb_cpu_sequencer;
  localparam int WAIT_LIMIT = 8;

  logic       tclk = 1'b0;
  logic       reset;
  logic       run;
  logic       c;
  logic       z;
  logic       alu_en;
  logic [7:0] ir;
  logic [1:0] state;
  logic [4:0] pc;
  logic       busy;
  logic       bus_err;

  cpu_sequencer_if bus();

  cpu_sequencer #(
    .RESET_PC   (5'd0),
    .WAIT_LIMIT (WAIT_LIMIT)
  ) dut (
    .tclk    (tclk),
    .reset   (reset),
    .run     (run),
    .bus     (bus),
    .c       (c),
    .z       (z),
    .alu_en  (alu_en),
    .ir      (ir),
    .state   (state),
    .pc      (pc),
    .busy    (busy),
    .bus_err (bus_err)
  );

  always #5 tclk = ~tclk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- memory responder ----------------
  logic [7:0] tb_mem [32];
  assign bus.mem_rdata = tb_mem[bus.addr];

  // Ready is withheld for exec_lat / write_lat cycles at the start of an
  // EXEC / WRITE access; stall withholds it indefinitely.
  int         exec_lat  = 0;
  int         write_lat = 0;
  bit         stall     = 1'b0;
  logic [1:0] resp_prev = 2'b00;
  int         resp_age  = 0;

  initial begin
    bus.mem_ready = 1'b0;
    forever begin
      @(posedge tclk);
      #1;
      if (state == resp_prev) resp_age++;
      else resp_age = 0;
      resp_prev = state;
      bus.mem_ready = (bus.mem_rd || bus.mem_wr) && !stall &&
                      (resp_age >= ((state == 2'b10) ? exec_lat :
                                    (state == 2'b11) ? write_lat : 0));
    end
  end

  // ---------------- instruction-level model ----------------
  // An instruction is a list of steps: step 0 fetches, step 1 executes,
  // step 2 (only for ALU results and ST) writes back. Memory steps stretch
  // until ready or until the wait limit runs out.
  bit         m_busy;
  bit         m_err;
  int         m_step;
  int         m_wait;
  logic [4:0] m_pc;
  logic [7:0] m_ir;

  function automatic bit op_reads(input logic [2:0] op);
    return (op == 3'd0) || (op == 3'd1) || (op == 3'd2) || (op == 3'd4);
  endfunction

  function automatic int op_steps(input logic [2:0] op);
    return (op == 3'd4 || op >= 3'd6) ? 2 : 3;
  endfunction

  always @(negedge tclk) begin : scoreboard
    logic [2:0] op;
    logic [4:0] opnd;
    logic [4:0] e_addr;
    bit         e_alu;
    bit         mem_phase;

    if (reset) begin
      m_busy = 1'b0;
      m_err  = 1'b0;
      m_step = 0;
      m_wait = 0;
      m_pc   = 5'd0;
      m_ir   = 8'h00;
    end
    op        = m_ir[7:5];
    opnd      = m_ir[4:0];
    e_addr    = !m_busy ? 5'd0 : (m_step == 0 ? m_pc : opnd);
    mem_phase = m_busy && (m_step != 1 || op_reads(op));
    e_alu     = m_busy && m_step == 1 &&
                (op_reads(op) ? bus.mem_ready : (op == 3'd3 || op == 3'd5));

    check("cyc_addr",    bus.addr,   e_addr);
    check("cyc_mem_rd",  bus.mem_rd, mem_phase && m_step < 2);
    check("cyc_mem_wr",  bus.mem_wr, m_busy && m_step == 2);
    check("cyc_bus_oe",  bus.bus_oe, m_busy && m_step == 2);
    check("cyc_alu_en",  alu_en,     e_alu);
    check("cyc_state",   state,      m_busy ? m_step + 1 : 0);
    check("cyc_busy",    busy,       m_busy);
    check("cyc_pc",      pc,         m_pc);
    check("cyc_ir",      ir,         m_ir);
    check("cyc_bus_err", bus_err,    m_err);

    if (!reset) begin
      if (!m_busy) begin
        if (run && !m_err) begin
          m_busy = 1'b1;
          m_step = 0;
        end
      end else if (mem_phase && !bus.mem_ready) begin
        m_wait++;
        if (m_wait == WAIT_LIMIT) begin
          m_err  = 1'b1;
          m_busy = 1'b0;
          m_wait = 0;
        end
      end else begin
        m_wait = 0;
        if (m_step == 0) begin
          m_ir   = tb_mem[m_pc];
          m_pc   = m_pc + 5'd1;
          m_step = 1;
        end else if (m_step + 1 < op_steps(op)) begin
          m_step++;
        end else begin
          if ((op == 3'd6 && c) || (op == 3'd7 && z)) m_pc = opnd;
          m_busy = run;
          m_step = 0;
        end
      end
    end
  end

  // ---------------- directed sequence ----------------
  task automatic drive_point();
    @(posedge tclk);
    #2;
  endtask

  task automatic sample();
    @(negedge tclk);
  endtask

  task automatic wait_for_state(input logic [1:0] s, input string tag);
    for (int i = 0; i < 64; i++) begin
      @(negedge tclk);
      if (state == s) return;
    end
    check(tag, state, s);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 32; i++) tb_mem[i] = 8'h00;
    tb_mem[0]  = 8'h85;  // LD 5
    tb_mem[1]  = 8'h03;  // ADD 3
    tb_mem[2]  = 8'hEA;  // JZ 10
    tb_mem[10] = 8'h7F;  // SHIFT 31
    tb_mem[11] = 8'hA4;  // ST 4
    tb_mem[12] = 8'hEA;  // JZ 10 (not taken)
    tb_mem[13] = 8'hDF;  // JC 31
    tb_mem[31] = 8'hE0;  // JZ 0 (not taken, pc wraps)

    reset = 1'b1;
    run   = 1'b0;
    c     = 1'b0;
    z     = 1'b0;

    // Reset values.
    repeat (2) sample();
    check("rst_state",   state,      2'b00);
    check("rst_pc",      pc,         5'd0);
    check("rst_ir",      ir,         8'h00);
    check("rst_busy",    busy,       1'b0);
    check("rst_addr",    bus.addr,   5'd0);
    check("rst_mem_rd",  bus.mem_rd, 1'b0);
    check("rst_mem_wr",  bus.mem_wr, 1'b0);
    check("rst_bus_oe",  bus.bus_oe, 1'b0);
    check("rst_alu_en",  alu_en,     1'b0);
    check("rst_bus_err", bus_err,    1'b0);

    // LD 5: FETCH, EXEC, back to FETCH two cycles after the first FETCH.
    drive_point();
    reset = 1'b0;
    run   = 1'b1;
    z     = 1'b1;
    sample();
    check("idle_until_edge", state, 2'b00);
    sample();
    check("ld_fetch_state",  state,      2'b01);
    check("ld_fetch_addr",   bus.addr,   5'd0);
    check("ld_fetch_rd",     bus.mem_rd, 1'b1);
    sample();
    check("ld_exec_state",   state,      2'b10);
    check("ld_exec_addr",    bus.addr,   5'd5);
    check("ld_exec_rd",      bus.mem_rd, 1'b1);
    check("ld_exec_alu_en",  alu_en,     1'b1);
    check("ld_exec_ir",      ir,         8'h85);
    exec_lat = 2;
    sample();
    check("ld_refetch_state", state, 2'b01);
    check("ld_refetch_pc",    pc,    5'd1);

    // ADD 3 with the operand read delayed two cycles.
    sample();
    check("add_exec_ir",   ir,     8'h03);
    check("add_wait0_alu", alu_en, 1'b0);
    sample();
    check("add_wait1_alu", alu_en, 1'b0);
    sample();
    check("add_ready_alu", alu_en, 1'b1);
    check("add_ready_rd",  bus.mem_rd, 1'b1);
    exec_lat = 0;
    sample();
    check("add_write_state", state,      2'b11);
    check("add_write_addr",  bus.addr,   5'd3);
    check("add_write_wr",    bus.mem_wr, 1'b1);
    check("add_write_oe",    bus.bus_oe, 1'b1);
    check("add_write_rd",    bus.mem_rd, 1'b0);
    check("add_write_alu",   alu_en,     1'b0);

    // JZ 10 taken.
    wait_for_state(2'b10, "jz_exec_timeout");
    check("jz_exec_ir", ir, 8'hEA);
    check("jz_exec_pc", pc, 5'd3);
    sample();
    check("jz_taken_state", state, 2'b01);
    check("jz_taken_pc",    pc,    5'd10);

    // SHIFT 31: one strobe, no read, then write to 31.
    wait_for_state(2'b10, "shift_exec_timeout");
    check("shift_ir",     ir,         8'h7F);
    check("shift_alu_en", alu_en,     1'b1);
    check("shift_rd",     bus.mem_rd, 1'b0);
    check("shift_addr",   bus.addr,   5'd31);
    sample();
    check("shift_write_state", state,      2'b11);
    check("shift_write_addr",  bus.addr,   5'd31);
    check("shift_write_wr",    bus.mem_wr, 1'b1);
    check("shift_write_alu",   alu_en,     1'b0);
    write_lat = 1;

    // ST 4 with run dropped while the write is still pending.
    wait_for_state(2'b10, "st_exec_timeout");
    check("st_ir",     ir,         8'hA4);
    check("st_alu_en", alu_en,     1'b1);
    check("st_rd",     bus.mem_rd, 1'b0);
    sample();
    check("st_write_addr", bus.addr,   5'd4);
    check("st_write_wr",   bus.mem_wr, 1'b1);
    check("st_write_oe",   bus.bus_oe, 1'b1);
    drive_point();
    run = 1'b0;
    sample();
    check("st_write_held", state, 2'b11);
    sample();
    check("st_park_state", state, 2'b00);
    check("st_park_busy",  busy,  1'b0);
    check("st_park_pc",    pc,    5'd12);
    write_lat = 0;
    repeat (3) begin
      sample();
      check("st_park_stays", state, 2'b00);
    end

    // JZ 10 not taken, then JC 31 taken, then JZ 0 at pc 31 (wrap).
    drive_point();
    run = 1'b1;
    z   = 1'b0;
    c   = 1'b1;
    wait_for_state(2'b10, "jz0_exec_timeout");
    check("jz_nt_ir", ir, 8'hEA);
    check("jz_nt_pc", pc, 5'd13);
    wait_for_state(2'b01, "jz0_fetch_timeout");
    check("jz_nt_after_pc", pc, 5'd13);
    wait_for_state(2'b10, "jc_exec_timeout");
    check("jc_ir", ir, 8'hDF);
    sample();
    check("jc_taken_state", state, 2'b01);
    check("jc_taken_pc",    pc,    5'd31);
    wait_for_state(2'b10, "wrap_exec_timeout");
    check("wrap_ir", ir, 8'hE0);
    check("wrap_pc", pc, 5'd0);

    // Fetch at pc 0 never gets ready: timeout after WAIT_LIMIT cycles.
    stall = 1'b1;
    for (int k = 0; k < WAIT_LIMIT; k++) begin
      sample();
      check("stall_fetch_state", state,   2'b01);
      check("stall_fetch_err",   bus_err, 1'b0);
    end
    sample();
    check("timeout_state", state,   2'b00);
    check("timeout_err",   bus_err, 1'b1);
    check("timeout_pc",    pc,      5'd0);
    repeat (10) begin
      sample();
      check("err_parks_idle", state, 2'b00);
    end

    // Reset clears the error; then reset again mid-EXEC.
    drive_point();
    reset    = 1'b1;
    stall    = 1'b0;
    exec_lat = 3;
    drive_point();
    reset = 1'b0;
    sample();
    check("err_cleared", bus_err, 1'b0);
    wait_for_state(2'b10, "midexec_timeout");
    check("midexec_ir", ir, 8'h85);
    drive_point();
    reset = 1'b1;
    #1;
    check("midrst_state",  state,      2'b00);
    check("midrst_pc",     pc,         5'd0);
    check("midrst_ir",     ir,         8'h00);
    check("midrst_addr",   bus.addr,   5'd0);
    check("midrst_mem_rd", bus.mem_rd, 1'b0);
    check("midrst_mem_wr", bus.mem_wr, 1'b0);
    check("midrst_alu_en", alu_en,     1'b0);
    check("midrst_busy",   busy,       1'b0);

    drive_point();
    reset = 1'b0;
    run   = 1'b0;
    repeat (3) sample();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
